// File: rtl/mmap_perf_pkg.sv
// mmap_perf_pkg
//   Shared constants for the memory-mapped performance-counter bank:
//   data word width, CTRL bit positions, fixed register offsets and
//   helpers that map a counter index to its lo/hi word offsets.
package mmap_perf_pkg;

  localparam int DATA_W = 16;

  // CTRL register bit positions
  localparam int CTRL_STATS_EN = 0;
  localparam int CTRL_CLR_ALL  = 1;
  localparam int CTRL_FREEZE   = 2;

  // Fixed word offsets
  localparam int OFS_CTRL    = 0;
  localparam int OFS_EN_MASK = 1;
  localparam int OFS_OVF     = 2;

  // Counter i occupies CNT_BASE+2i (lo) and CNT_BASE+2i+1 (hi)
  localparam int CNT_BASE = 4;

  function automatic int cnt_lo_ofs(input int idx);
    return CNT_BASE + 2 * idx;
  endfunction

  function automatic int cnt_hi_ofs(input int idx);
    return CNT_BASE + 2 * idx + 1;
  endfunction

endpackage

// File: rtl/perf_cntr.sv
// perf_cntr
//   One event counter of the performance-counter bank.
//   Ports:
//     clk       - clock
//     rst       - synchronous active-high reset
//     clr       - synchronous clear (clr_all), same effect as reset
//     inc_en    - count qualifier, already gated by the enables
//     value     - current count
//     ovf_pulse - high in a cycle where an increment hits an all-ones count
module perf_cntr #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  output logic [CNT_W-1:0] value,
  output logic             ovf_pulse
);

  logic [CNT_W-1:0] r_value;
  logic             w_at_max;

  assign w_at_max  = &r_value;
  assign ovf_pulse = inc_en & w_at_max;
  assign value     = r_value;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_value <= '0;
    end else if (inc_en) begin
      if (!w_at_max) begin
        r_value <= r_value + CNT_W'(1);
      end else if (!SATURATE) begin
        r_value <= '0;
      end
      // saturating: hold at all-ones
    end
  end

endmodule

// File: rtl/mmap_perf_cntrs.sv
// mmap_perf_cntrs
//   Memory-mapped bank of NUM_CNT event counters with global enable,
//   freeze, clear-all, per-counter enable mask and sticky overflow flags.
//   Wide counters are read lo word first; the lo read snapshots the upper
//   bits into a single shared shadow register that the hi read returns.
//   Ports:
//     clk       - clock
//     rst       - synchronous active-high reset
//     mmap_re   - decoded read strobe
//     mmap_we   - decoded write strobe
//     mmap_addr - word offset within the block
//     databus   - bidirectional data; driven only while mmap_re is high
//     inc       - per-counter one-cycle event pulses
//     ovf_any   - registered OR of all overflow flags
module mmap_perf_cntrs
  import mmap_perf_pkg::*;
#(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 32,
  parameter int ADDR_W   = 5,
  parameter int SATURATE = 0,
  parameter int CYC_CNT0 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mmap_re,
  input  logic                mmap_we,
  input  logic [ADDR_W-1:0]   mmap_addr,
  inout  wire  [DATA_W-1:0]   databus,
  input  logic [NUM_CNT-1:0]  inc,
  output logic                ovf_any
);

  logic               r_stats_en;
  logic               r_freeze;
  logic [NUM_CNT-1:0] r_en_mask;
  logic [NUM_CNT-1:0] r_ovf;
  logic               r_ovf_any;
  logic [DATA_W-1:0]  r_shadow_hi;

  int                 w_addr;
  logic               w_wr;
  logic               w_clr;
  logic [NUM_CNT-1:0] w_event;
  logic [NUM_CNT-1:0] w_inc_en;
  logic [NUM_CNT-1:0] w_ovf_pulse;
  logic [NUM_CNT-1:0] w_ovf_w1c;
  logic [NUM_CNT-1:0] w_ovf_next;
  logic [CNT_W-1:0]   w_cnt [NUM_CNT];
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_unused;

  assign w_addr = int'(mmap_addr);

  // A simultaneous read wins: the bus carries our own read data then.
  assign w_wr  = mmap_we & ~mmap_re;
  assign w_clr = w_wr && (w_addr == OFS_CTRL) && databus[CTRL_CLR_ALL];

  // Bus bits beyond the implemented fields, and inc[0] when counter 0
  // counts cycles, are intentionally ignored.
  assign w_unused = ^{databus, inc};

  // --------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    if (gi == 0 && CYC_CNT0 != 0) begin : g_cyc
      assign w_event[gi] = 1'b1;
    end else begin : g_evt
      assign w_event[gi] = inc[gi];
    end

    assign w_inc_en[gi] = r_stats_en & ~r_freeze & r_en_mask[gi] & w_event[gi];

    perf_cntr #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE != 0)
    ) u_cntr (
      .clk       (clk),
      .rst       (rst),
      .clr       (w_clr),
      .inc_en    (w_inc_en[gi]),
      .value     (w_cnt[gi]),
      .ovf_pulse (w_ovf_pulse[gi])
    );
  end

  // --------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stats_en <= 1'b0;
      r_freeze   <= 1'b0;
      r_en_mask  <= '1;
    end else if (w_wr) begin
      if (w_addr == OFS_CTRL) begin
        r_stats_en <= databus[CTRL_STATS_EN];
        r_freeze   <= databus[CTRL_FREEZE];
      end
      if (w_addr == OFS_EN_MASK) begin
        r_en_mask <= databus[NUM_CNT-1:0];
      end
    end
  end

  // --------------------------------------------------------------------
  // Overflow flags: a new overflow beats a write-1-clear of the same bit,
  // clr_all beats both.
  // --------------------------------------------------------------------
  assign w_ovf_w1c  = (w_wr && w_addr == OFS_OVF) ? databus[NUM_CNT-1:0] : '0;
  assign w_ovf_next = w_clr ? '0 : ((r_ovf & ~w_ovf_w1c) | w_ovf_pulse);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= '0;
      r_ovf_any <= 1'b0;
    end else begin
      r_ovf     <= w_ovf_next;
      r_ovf_any <= |w_ovf_next;
    end
  end

  assign ovf_any = r_ovf_any;

  // --------------------------------------------------------------------
  // Shadow of the upper counter bits, captured on any lo-word read.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_shadow_hi <= '0;
    end else if (mmap_re) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_addr == cnt_lo_ofs(i)) begin
          r_shadow_hi <= DATA_W'(w_cnt[i][CNT_W-1:DATA_W]);
        end
      end
    end
  end

  // --------------------------------------------------------------------
  // Read mux; unmapped and reserved offsets fall through to zero.
  // --------------------------------------------------------------------
  always_comb begin
    w_rd_data = '0;
    if (w_addr == OFS_CTRL) begin
      w_rd_data[CTRL_STATS_EN] = r_stats_en;
      w_rd_data[CTRL_FREEZE]   = r_freeze;
    end else if (w_addr == OFS_EN_MASK) begin
      w_rd_data[NUM_CNT-1:0] = r_en_mask;
    end else if (w_addr == OFS_OVF) begin
      w_rd_data[NUM_CNT-1:0] = r_ovf;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_addr == cnt_lo_ofs(i)) begin
        w_rd_data = w_cnt[i][DATA_W-1:0];
      end
      if (w_addr == cnt_hi_ofs(i)) begin
        w_rd_data = r_shadow_hi;
      end
    end
  end

  assign databus = mmap_re ? w_rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mmap_perf_cntrs.sv
module tb_mmap_perf_cntrs;

  localparam int NA = 4;
  localparam int WA = 32;
  localparam int NB = 3;
  localparam int WB = 20;
  localparam longint unsigned MAXA = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          re_a, we_a, re_b, we_b, oe_a, oe_b;
  logic [4:0]    addr;
  logic [15:0]   drv;
  wire  [15:0]   bus_a;
  wire  [15:0]   bus_b;
  logic [NA-1:0] inc_a;
  logic [NB-1:0] inc_b;
  logic          ovf_any_a, ovf_any_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign bus_a = oe_a ? drv : 16'hzzzz;
  assign bus_b = oe_b ? drv : 16'hzzzz;

  // A: wrapping, 32-bit, counter 0 counts cycles
  mmap_perf_cntrs #(.NUM_CNT(NA), .CNT_W(WA), .ADDR_W(5), .SATURATE(0), .CYC_CNT0(1)) u_a (
    .clk(clk), .rst(rst), .mmap_re(re_a), .mmap_we(we_a), .mmap_addr(addr),
    .databus(bus_a), .inc(inc_a), .ovf_any(ovf_any_a));

  // B: saturating, 20-bit, three counters, counter 0 counts events
  mmap_perf_cntrs #(.NUM_CNT(NB), .CNT_W(WB), .ADDR_W(5), .SATURATE(1), .CYC_CNT0(0)) u_b (
    .clk(clk), .rst(rst), .mmap_re(re_b), .mmap_we(we_b), .mmap_addr(addr),
    .databus(bus_b), .inc(inc_b), .ovf_any(ovf_any_b));

  // reference model for A
  longint unsigned m_cnt [NA];
  bit              m_en, m_frz;
  bit [NA-1:0]     m_mask, m_ovf;
  logic [15:0]     m_shadow;

  typedef struct {
    bit          wr;
    int          a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input bit b, input int a, input logic [15:0] d);
    addr = 5'(a);
    drv  = d;
    if (b) begin oe_b = 1'b1; we_b = 1'b1; end
    else   begin oe_a = 1'b1; we_a = 1'b1; end
    @(posedge clk); #1;
    oe_a = 1'b0; oe_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic rd(input bit b, input int a, input logic [15:0] exp, input string nm);
    addr = 5'(a);
    if (b) re_b = 1'b1; else re_a = 1'b1;
    #2;
    check(nm, 32'(b ? bus_b : bus_a), 32'(exp));
    @(posedge clk); #1;
    re_a = 1'b0; re_b = 1'b0;
  endtask

  task automatic pulse_a(input logic [NA-1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      inc_a = m;
      @(posedge clk); #1;
    end
    inc_a = '0;
  endtask

  task automatic pulse_b(input logic [NB-1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      inc_b = m;
      @(posedge clk); #1;
    end
    inc_b = '0;
  endtask

  function automatic logic [15:0] m_read(input int a);
    logic [15:0] r;
    r = '0;
    if (a == 0)      r = {13'b0, m_frz, 1'b0, m_en};
    else if (a == 1) r = {12'b0, m_mask};
    else if (a == 2) r = {12'b0, m_ovf};
    else if (a >= 4 && a < 4 + 2 * NA) r = (a % 2 == 0) ? 16'(m_cnt[(a - 4) / 2]) : m_shadow;
    return r;
  endfunction

  task automatic rand_step();
    int          op, a;
    logic [15:0] d;
    logic [NA-1:0] iv;
    logic [NA-1:0] set;
    bit          w, clr, ev;
    op  = $urandom_range(0, 6);
    a   = $urandom_range(0, 31);
    d   = 16'($urandom);
    iv  = NA'($urandom);
    if (op == 1) begin
      a = 0;
      d[0] = ($urandom_range(0, 3) != 0);
      d[1] = ($urandom_range(0, 7) == 0);
      d[2] = ($urandom_range(0, 3) == 0);
    end
    if (op == 2) a = 1;
    if (op == 3) a = 2;
    if (op == 4) a = 4 + $urandom_range(0, 2 * NA - 1);
    addr  = 5'(a);
    inc_a = iv;
    drv   = d;
    case (op)
      1, 2, 3: begin oe_a = 1'b1; we_a = 1'b1; end
      4, 5:    re_a = 1'b1;
      6:       begin re_a = 1'b1; we_a = 1'b1; end
      default: ;
    endcase
    #2;
    if (re_a) check("rand_rd", 32'(bus_a), 32'(m_read(a)));
    check("rand_ovf_any", 32'(ovf_any_a), 32'(m_ovf != 0));
    w   = we_a && !re_a;
    clr = w && a == 0 && d[1];
    set = '0;
    if (re_a && a >= 4 && a < 4 + 2 * NA && a % 2 == 0)
      m_shadow = 16'(m_cnt[(a - 4) / 2] >> 16);
    for (int i = 0; i < NA; i++) begin
      ev = (i == 0) || iv[i];
      if (m_en && !m_frz && m_mask[i] && ev) begin
        if (m_cnt[i] == MAXA) begin set[i] = 1'b1; m_cnt[i] = 0; end
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (w && a == 2) m_ovf = m_ovf & ~d[NA-1:0];
    m_ovf = m_ovf | set;
    if (w && a == 0) begin m_en = d[0]; m_frz = d[2]; end
    if (w && a == 1) m_mask = d[NA-1:0];
    if (clr) begin
      for (int i = 0; i < NA; i++) m_cnt[i] = 0;
      m_ovf = '0;
      m_shadow = '0;
    end
    @(posedge clk); #1;
    oe_a = 1'b0; we_a = 1'b0; re_a = 1'b0; inc_a = '0;
  endtask

  initial begin
    rst = 1'b1;
    re_a = 0; we_a = 0; re_b = 0; we_b = 0; oe_a = 0; oe_b = 0;
    addr = '0; drv = '0; inc_a = '0; inc_b = '0;

    vt[0]  = '{0, 0,  16'h0000, 16'h0000};
    vt[1]  = '{0, 1,  16'h0000, 16'h0007};
    vt[2]  = '{0, 2,  16'h0000, 16'h0000};
    vt[3]  = '{0, 3,  16'h0000, 16'h0000};
    vt[4]  = '{1, 3,  16'hFFFF, 16'h0000};
    vt[5]  = '{0, 3,  16'h0000, 16'h0000};
    vt[6]  = '{1, 1,  16'hFFFF, 16'h0000};
    vt[7]  = '{0, 1,  16'h0000, 16'h0007};
    vt[8]  = '{1, 0,  16'hFFFF, 16'h0000};
    vt[9]  = '{0, 0,  16'h0000, 16'h0005};
    vt[10] = '{1, 4,  16'h1234, 16'h0000};
    vt[11] = '{0, 4,  16'h0000, 16'h0000};
    vt[12] = '{0, 5,  16'h0000, 16'h0000};
    vt[13] = '{0, 10, 16'h0000, 16'h0000};
    vt[14] = '{0, 31, 16'h0000, 16'h0000};
    vt[15] = '{1, 0,  16'h0000, 16'h0000};
    vt[16] = '{0, 0,  16'h0000, 16'h0000};
    vt[17] = '{1, 1,  16'h0005, 16'h0000};
    vt[18] = '{0, 1,  16'h0000, 16'h0005};
    vt[19] = '{1, 1,  16'h0007, 16'h0000};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ovf_any_a", 32'(ovf_any_a), 32'd0);
    check("rst_ovf_any_b", 32'(ovf_any_b), 32'd0);

    // register map on B
    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) wr(1, vt[i].a, vt[i].d);
      else rd(1, vt[i].a, vt[i].exp, $sformatf("map_%0d_ofs%0d", i, vt[i].a));
    end

    // defaults
    wr(0, 0, 16'h0001);
    pulse_a(4'b0010, 5);
    rd(0, 6, 16'h0005, "dflt_c1_lo");
    rd(0, 7, 16'h0000, "dflt_c1_hi");
    rd(0, 2, 16'h0000, "dflt_ovf");

    // enable mask
    wr(0, 0, 16'h0003);
    wr(0, 1, 16'h000D);
    pulse_a(4'hF, 3);
    rd(0, 6,  16'h0000, "mask_c1");
    rd(0, 8,  16'h0003, "mask_c2");
    rd(0, 10, 16'h0003, "mask_c3");

    // freeze
    wr(0, 0, 16'h0005);
    pulse_a(4'hF, 2);
    rd(0, 8, 16'h0003, "frz_c2");
    rd(0, 0, 16'h0005, "frz_ctrl");
    wr(0, 0, 16'h0001);
    pulse_a(4'hF, 1);
    rd(0, 8, 16'h0004, "resume_c2");
    rd(0, 6, 16'h0000, "resume_c1_masked");

    // wrap and overflow
    wr(0, 1, 16'h000F);
    u_a.g_cnt[1].u_cntr.r_value = 32'hFFFF_FFFF;
    pulse_a(4'b0010, 1);
    check("wrap_ovf_any", 32'(ovf_any_a), 32'd1);
    rd(0, 6, 16'h0000, "wrap_lo");
    rd(0, 7, 16'h0000, "wrap_hi");
    rd(0, 2, 16'h0002, "wrap_ovf");
    u_a.g_cnt[1].u_cntr.r_value = 32'hFFFF_FFFF;
    inc_a = 4'b0010;
    wr(0, 2, 16'h0002);
    inc_a = '0;
    rd(0, 2, 16'h0002, "ovf_set_beats_clr");
    addr = 5'd2; re_a = 1'b1; we_a = 1'b1;
    @(posedge clk); #1;
    re_a = 1'b0; we_a = 1'b0;
    rd(0, 2, 16'h0002, "rdwr_write_ignored");
    wr(0, 2, 16'h0002);
    rd(0, 2, 16'h0000, "ovf_w1c");
    check("ovf_any_cleared", 32'(ovf_any_a), 32'd0);

    // coherent wide read
    u_a.g_cnt[0].u_cntr.r_value = 32'h0001_FFFF;
    rd(0, 4, 16'hFFFF, "coh_lo");
    rd(0, 5, 16'h0001, "coh_hi");
    rd(0, 4, 16'h0001, "coh_lo2");
    rd(0, 5, 16'h0002, "coh_hi2");

    // clr_all with concurrent increments and overflow
    u_a.g_cnt[3].u_cntr.r_value = 32'hFFFF_FFFF;
    inc_a = 4'hF;
    wr(0, 0, 16'h0003);
    inc_a = '0;
    rd(0, 5,  16'h0000, "clr_shadow");
    rd(0, 4,  16'h0001, "clr_c0");
    rd(0, 10, 16'h0000, "clr_c3");
    rd(0, 2,  16'h0000, "clr_ovf");
    check("clr_ovf_any", 32'(ovf_any_a), 32'd0);

    // saturate on B
    wr(1, 0, 16'h0001);
    u_b.g_cnt[1].u_cntr.r_value = 20'hFFFFF;
    pulse_b(3'b010, 1);
    check("sat_ovf_any", 32'(ovf_any_b), 32'd1);
    rd(1, 6, 16'hFFFF, "sat_lo");
    rd(1, 7, 16'h000F, "sat_hi");
    rd(1, 2, 16'h0002, "sat_ovf");
    wr(1, 2, 16'h0002);
    rd(1, 2, 16'h0000, "sat_w1c");
    pulse_b(3'b010, 1);
    rd(1, 2, 16'h0002, "sat_reovf");
    rd(1, 6, 16'hFFFF, "sat_hold");
    pulse_b(3'b001, 2);
    rd(1, 4, 16'h0002, "b_c0_events");

    // reset mid-count
    wr(0, 0, 16'h0001);
    inc_a = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    inc_a = '0;
    rd(0, 4, 16'h0000, "rst_c0");
    rd(0, 8, 16'h0000, "rst_c2");
    rd(0, 0, 16'h0000, "rst_ctrl");
    rd(0, 1, 16'h000F, "rst_mask");

    // randomized against the model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NA; i++) m_cnt[i] = 0;
    m_en = 0; m_frz = 0; m_mask = '1; m_ovf = '0; m_shadow = '0;
    for (int s = 0; s < 400; s++) rand_step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mmap_perf_cntrs.md
Name: mmap_perf_cntrs

Overview:
- Parametrised memory-mapped performance-counter bank; next generation of the branch-statistics registers.
- Provides NUM_CNT event counters of CNT_W bits, each with its own enable, plus a global enable, freeze, clear-all, sticky overflow flags and an optional wrap or saturate mode.
- Wide counters are read as lo and hi 16-bit words over the shared tri-state databus; a shadow register keeps the two halves coherent.
- Sits on the CPU memory-mapped I/O decode; event pulses come from the branch predictor and the pipeline.

Parameters:
- NUM_CNT, 4: number of event counters, 1..14.
- CNT_W, 32: counter width, 17..32. Bits above CNT_W in the hi word read as 0.
- ADDR_W, 5: width of the word-address offset.
- SATURATE, 0: 0 = counter wraps to 0; 1 = counter holds at all-ones.
- CYC_CNT0, 1: 1 = counter 0 counts every cycle while enabled and ignores inc[0].

Ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- mmap_re, input, 1: read strobe for this block, already decoded.
- mmap_we, input, 1: write strobe for this block, already decoded.
- mmap_addr, input, ADDR_W: word offset within the block.
- databus, inout, 16: write data in; read data out while mmap_re is high, otherwise 16'hzzzz.
- inc, input, NUM_CNT: one-cycle event pulses, one bit per counter.
- ovf_any, output, 1: OR of all overflow flags.

Behaviour:
Register map (word offsets):
- 0, CTRL:
  - bit0 stats_en, read/write.
  - bit1 clr_all, write-1 pulse; always reads 0.
  - bit2 freeze, read/write.
  - Other bits read 0.
- 1, EN_MASK: read/write; bit i enables counter i. Bits at NUM_CNT and above read 0.
- 2, OVF: sticky overflow flags. Write 1 to a bit clears that flag.
- 3: reserved; reads 0, writes ignored.
- 4+2i: counter i lo word, bits [15:0].
- 5+2i: counter i hi word, taken from the shadow register.
- Offsets beyond 3+2*NUM_CNT read 0; writes to them are ignored.

Read path:
- Combinational in the same cycle: databus is driven while mmap_re is high.
- A read of counter i lo word captures the live counter bits [CNT_W-1:16] into the single shared shadow_hi on that clock edge.
- A hi read returns shadow_hi, which holds the value captured at the latest lo read of any counter.

Write path:
- databus is sampled on the clock edge where mmap_we is high.
- Counter words are read-only; writes to them are ignored.
- mmap_re and mmap_we high together: the read is serviced and the write is ignored.

Count rule, evaluated per cycle:
- Counter i increments when stats_en=1, freeze=0, EN_MASK[i]=1 and the event is present.
- The event is inc[i], or a constant 1 for counter 0 when CYC_CNT0=1.

Overflow:
- Incrementing from all-ones sets OVF[i].
- The counter then becomes 0 (SATURATE=0) or stays all-ones (SATURATE=1). With SATURATE=1, each further event at all-ones sets OVF[i] again.
- An overflow set and a write-1-clear in the same cycle: the set wins.

clr_all:
- Zeroes every counter, OVF and shadow_hi on that edge.
- clr_all beats a simultaneous increment or overflow.
- stats_en, freeze and EN_MASK take the written values in the same write.

Reset (rst=1 at a clock edge):
- All counters, OVF and shadow_hi become 0.
- stats_en=0, freeze=0, EN_MASK=all-ones over NUM_CNT bits.
- ovf_any=0.
- Reset asserted mid-count discards every count.

ovf_any is registered; it follows OVF with no extra latency beyond the flag register.

Decomposition:
- Package mmap_perf_pkg holds:
  - the CTRL bit-index constants;
  - the offsets for CTRL, EN_MASK and OVF;
  - CNT_BASE = 4;
  - the lo/hi offset function of the counter index.
- One sub-module, perf_cntr, per counter: width CNT_W and the SATURATE parameter.
  - Inputs: clk, rst, clr, inc_en.
  - Outputs: value and ovf_pulse.
- Generated NUM_CNT times by the top level.

Test Plan:
- Defaults: after reset, write CTRL=1, pulse inc[1] 5 times, then read offset 6 -> 16'h0005; read offset 7 -> 16'h0000; read offset 2 -> 16'h0000.
- EN_MASK: write EN_MASK=4'b1101, pulse all inc bits 3 times -> counter 1 reads 0; counters 2 and 3 read 3.
- Freeze: set CTRL=5, pulse inc -> no counter changes. Then write CTRL=1 -> counting resumes.
- Wrap: drive counter 1 to 32'hFFFF_FFFF and pulse once -> counter reads 0, OVF=16'h0002, ovf_any=1. Write OVF=2 in the same cycle as another overflow -> flag stays 1.
- Saturate: repeat the wrap test with SATURATE=1 -> counter stays FFFF_FFFF and OVF[1] is set.
- Coherent read: with counter 0 at 32'h0001_FFFF, read lo (FFFF); the counter then ticks; read hi -> 16'h0001, not 16'h0002. clr_all concurrent with inc -> all counters 0.
